// File: rtl/regfile_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_arb_pkg
// Brief    : Shared state encoding and default sizing for regfile_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_arb_pkg;

    localparam int c_default_num_req    = 4;
    localparam int c_default_data_width = 8;
    localparam int c_default_addr_width = 4;

    typedef logic [0:0] state_t;

    localparam state_t c_st_idle   = 1'b0;
    localparam state_t c_st_access = 1'b1;

endpackage : regfile_arb_pkg
`default_nettype wire

// File: rtl/regfile_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational round-robin pick, searching upward from last+1.
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [IDX_W-1:0]   i_last,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_idx
);

    localparam logic [IDX_W:0] c_num = (IDX_W+1)'(NUM_REQ);

    logic [NUM_REQ-1:0] w_eligible;
    logic [IDX_W:0]     w_cand;

    assign w_eligible = i_req & ~i_mask;

    // The final offset (k == NUM_REQ) revisits last itself, so an unmasked
    // lone requester can still win.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, i_last} + (IDX_W+1)'(k);
            if (w_cand >= c_num) begin
                w_cand = w_cand - c_num;
            end
            if (!o_found && w_eligible[w_cand[IDX_W-1:0]]) begin
                o_found = 1'b1;
                o_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_arbiter
// Brief    : Round-robin arbiter granting one register-file access per cycle.
//            Optional REGFILE_ARB_LOCK_EN adds req_lock for back-to-back grants.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ    = c_default_num_req,
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int ADDR_WIDTH = c_default_addr_width
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
`ifdef REGFILE_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]             req_lock,
`endif
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic [ADDR_WIDTH-1:0]          rf_address,
    output logic                           rf_write_enable,
    output logic [DATA_WIDTH-1:0]          rf_write_data,
    input  logic [DATA_WIDTH-1:0]          rf_read_data
);

    localparam int c_idx_w = $clog2(NUM_REQ);

    state_t                  r_state;
    logic [c_idx_w-1:0]      r_last_winner;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_data;

    logic                    w_in_access;
    logic [NUM_REQ-1:0]      w_cur_onehot;
    logic [NUM_REQ-1:0]      w_mask;
    logic                    w_found;
    logic [c_idx_w-1:0]      w_pick_idx;
    logic                    w_lock_hit;
    logic                    w_take;
    logic [c_idx_w-1:0]      w_sel;

    // During ACCESS the last winner is the requester currently being served.
    assign w_in_access  = (r_state == c_st_access);
    assign w_cur_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_last_winner;
    assign w_mask       = w_in_access ? w_cur_onehot : '0;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_rr_picker (
        .i_req   (req),
        .i_mask  (w_mask),
        .i_last  (r_last_winner),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

`ifdef REGFILE_ARB_LOCK_EN
    assign w_lock_hit = w_in_access && req[r_last_winner] && req_lock[r_last_winner];
`else
    assign w_lock_hit = 1'b0;
`endif

    assign w_take = w_lock_hit | w_found;
    assign w_sel  = w_lock_hit ? r_last_winner : w_pick_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= c_st_idle;
            r_last_winner <= c_idx_w'(NUM_REQ - 1);
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rsp_valid   <= '0;
            r_rsp_data    <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (w_in_access && !r_we) begin
                r_rsp_valid <= w_cur_onehot;
                r_rsp_data  <= rf_read_data;
            end
            if (w_take) begin
                r_state       <= c_st_access;
                r_last_winner <= w_sel;
                r_we          <= req_we[w_sel];
                r_addr        <= req_addr[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
                r_wdata       <= req_wdata[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                r_state <= c_st_idle;
            end
        end
    end

    // Write enable is decoded from the state register so reset kills it at once.
    assign gnt             = w_mask;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_data        = r_rsp_data;
    assign rf_address      = r_addr;
    assign rf_write_enable = w_in_access & r_we;
    assign rf_write_data   = r_wdata;

endmodule : regfile_arbiter
`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_arbiter
// Brief    : Randomized bench for regfile_arbiter with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_arbiter;

    localparam int c_n  = 4;
    localparam int c_dw = 8;
    localparam int c_aw = 4;

    logic                 clk;
    logic                 reset;
    logic [c_n-1:0]       req;
    logic [c_n-1:0]       req_we;
    logic [c_n*c_aw-1:0]  req_addr;
    logic [c_n*c_dw-1:0]  req_wdata;
`ifdef REGFILE_ARB_LOCK_EN
    logic [c_n-1:0]       req_lock;
`endif
    logic [c_n-1:0]       gnt;
    logic [c_n-1:0]       rsp_valid;
    logic [c_dw-1:0]      rsp_data;
    logic [c_aw-1:0]      rf_address;
    logic                 rf_write_enable;
    logic [c_dw-1:0]      rf_write_data;
    logic [c_dw-1:0]      rf_read_data;

    logic [c_dw-1:0]      rf_mem [16];
    logic                 mem_clear;

    int n_checks;
    int n_fail;

    // Reference state: who is being served and what it asked for.
    bit                   m_access;
    int                   m_cur;
    int                   m_last;
    bit                   m_we;
    logic [c_aw-1:0]      m_addr;
    logic [c_dw-1:0]      m_wdata;
    logic [c_n-1:0]       m_rsp_valid;
    logic [c_dw-1:0]      m_rsp_data;
    logic [c_dw-1:0]      model_mem [16];

    regfile_arbiter #(
        .NUM_REQ    (c_n),
        .DATA_WIDTH (c_dw),
        .ADDR_WIDTH (c_aw)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
`ifdef REGFILE_ARB_LOCK_EN
        .req_lock        (req_lock),
`endif
        .gnt             (gnt),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rf_address      (rf_address),
        .rf_write_enable (rf_write_enable),
        .rf_write_data   (rf_write_data),
        .rf_read_data    (rf_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_read_data = rf_mem[rf_address];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
        end else if (rf_write_enable) begin
            rf_mem[rf_address] <= rf_write_data;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_access    = 1'b0;
        m_cur       = 0;
        m_last      = c_n - 1;
        m_rsp_valid = '0;
    endtask

    // One clock: advance the reference from the inputs seen at the edge, then compare.
    task automatic step();
        int  pick;
        bit  lock_hit;
        @(posedge clk);
        m_rsp_valid = '0;
        if (m_access) begin
            if (m_we) begin
                model_mem[m_addr] = m_wdata;
            end else begin
                m_rsp_valid = c_n'(1) << m_cur;
                m_rsp_data  = model_mem[m_addr];
            end
        end
        lock_hit = 1'b0;
`ifdef REGFILE_ARB_LOCK_EN
        if (m_access && req[m_cur] && req_lock[m_cur]) lock_hit = 1'b1;
`endif
        pick = -1;
        if (lock_hit) begin
            pick = m_cur;
        end else begin
            for (int k = 1; k <= c_n; k++) begin
                int cand;
                cand = (m_last + k) % c_n;
                if (pick < 0 && req[cand] && !(m_access && cand == m_cur)) pick = cand;
            end
        end
        if (pick >= 0) begin
            m_access = 1'b1;
            m_cur    = pick;
            m_last   = pick;
            m_we     = req_we[pick];
            m_addr   = req_addr[pick*c_aw +: c_aw];
            m_wdata  = req_wdata[pick*c_dw +: c_dw];
        end else begin
            m_access = 1'b0;
        end
        #1;
        check_val("gnt", 32'(gnt), m_access ? 32'(c_n'(1) << m_cur) : 32'd0);
        check_val("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        check_val("rf_we", 32'(rf_write_enable), 32'(m_access && m_we));
        if (m_access) check_val("rf_addr", 32'(rf_address), 32'(m_addr));
        if (m_access && m_we) check_val("rf_wdata", 32'(rf_write_data), 32'(m_wdata));
        check_val("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
        if (m_rsp_valid != '0) check_val("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
    endtask

    task automatic set_req(input int i, input bit we, input logic [c_aw-1:0] a, input logic [c_dw-1:0] d);
        req[i]                = 1'b1;
        req_we[i]             = we;
        req_addr[i*c_aw +: c_aw] = a;
        req_wdata[i*c_dw +: c_dw] = d;
    endtask

    task automatic raise_random(input int i);
        set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
`ifdef REGFILE_ARB_LOCK_EN
        req_lock[i] = ($urandom_range(0, 3) == 0);
`endif
    endtask

    task automatic clear_reqs();
        req = '0;
`ifdef REGFILE_ARB_LOCK_EN
        req_lock = '0;
`endif
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        clear_reqs();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("rst_gnt", 32'(gnt), 32'd0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_val("rst_rf_we", 32'(rf_write_enable), 32'd0);
        check_val("rst_rf_addr", 32'(rf_address), 32'd0);
        check_val("rst_rf_wdata", 32'(rf_write_data), 32'd0);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        mem_clear = 1'b1;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        reset_dut();
        mem_clear = 1'b0;

        // Seed rf[3]=A5 with requester 0, then requester 1 reads it back.
        set_req(0, 1'b1, 4'd3, 8'hA5);
        step();
        req[0] = 1'b0;
        step();
        set_req(1, 1'b0, 4'd3, 8'h00);
        step();
        check_val("read_gnt_t1", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        step();
        check_val("read_valid_t2", 32'(rsp_valid), 32'h2);
        check_val("read_data_a5", 32'(rsp_data), 32'hA5);

        // Requester 2 writes 3C to 7; requester 3 reads 7.
        set_req(2, 1'b1, 4'd7, 8'h3C);
        step();
        check_val("write_we", 32'(rf_write_enable), 32'd1);
        check_val("write_addr7", 32'(rf_address), 32'd7);
        req[2] = 1'b0;
        step();
        check_val("write_we_drop", 32'(rf_write_enable), 32'd0);
        set_req(3, 1'b0, 4'd7, 8'h00);
        step();
        req[3] = 1'b0;
        step();
        check_val("readback_3c", 32'(rsp_data), 32'h3C);

        // All four requesters held continuously from reset.
        reset_dut();
        for (int i = 0; i < c_n; i++) set_req(i, 1'b0, 4'(i), 8'h00);
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("rr_order", 32'(gnt), 32'(c_n'(1) << (k % c_n)));
        end
        clear_reqs();
        step();
        step();

        // Wrap-around from last winner 3 with req 1001.
        reset_dut();
        set_req(0, 1'b0, 4'd1, 8'h00);
        set_req(3, 1'b0, 4'd2, 8'h00);
        step();
        check_val("wrap_gnt0", 32'(gnt), 32'h1);
        req[0] = 1'b0;
        step();
        check_val("wrap_gnt3", 32'(gnt), 32'h8);
        req[3] = 1'b0;
        step();
        step();

        // Reset pulsed in the middle of a write access.
        set_req(1, 1'b1, 4'd5, 8'h77);
        step();
        check_val("rstw_we_before", 32'(rf_write_enable), 32'd1);
        req[1] = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_val("rstw_we_async", 32'(rf_write_enable), 32'd0);
        check_val("rstw_gnt_async", 32'(gnt), 32'd0);
        @(posedge clk);
        #1;
        check_val("rstw_no_rsp", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        model_reset();
        set_req(0, 1'b0, 4'd5, 8'h00);
        set_req(1, 1'b0, 4'd3, 8'h00);
        step();
        check_val("rstw_next_gnt0", 32'(gnt), 32'h1);
        req[0] = 1'b0;
        step();
        req[1] = 1'b0;
        step();
        step();

`ifdef REGFILE_ARB_LOCK_EN
        // Requester 1 locks for three accesses while requester 2 waits.
        reset_dut();
        set_req(1, 1'b0, 4'd3, 8'h00);
        req_lock[1] = 1'b1;
        set_req(2, 1'b0, 4'd7, 8'h00);
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("lock_gnt1", 32'(gnt), 32'h2);
        end
        req[1]      = 1'b0;
        req_lock[1] = 1'b0;
        step();
        check_val("lock_then_gnt2", 32'(gnt), 32'h4);
        req[2] = 1'b0;
        step();
        step();
`endif

        // Random traffic: requesters hold until granted, sometimes re-request at once.
        for (int cyc = 0; cyc < 600; cyc++) begin
            step();
            for (int i = 0; i < c_n; i++) begin
                if (m_access && m_cur == i) begin
                    if ($urandom_range(0, 3) == 0) begin
                        raise_random(i);
                    end else begin
                        req[i] = 1'b0;
                        req_we[i] = 1'($urandom_range(0, 1));
                        req_addr[i*c_aw +: c_aw] = 4'($urandom_range(0, 15));
`ifdef REGFILE_ARB_LOCK_EN
                        req_lock[i] = 1'b0;
`endif
                    end
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    raise_random(i);
                end
            end
        end
        clear_reqs();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_arbiter
`default_nettype wire
